pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_chk.sv | 19 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_WIDTH  = 32;

  // Enable/clear pair driven into one inter-stage register.
  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctrl_t;

  // RUN: normal operation. KILL: a fetch issued before a redirect is still outstanding.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    KILL = 1'b1
  } hz_state_e;

  localparam stage_ctrl_t STAGE_RUN   = '{en: 1'b1, clr: 1'b0};
  localparam stage_ctrl_t STAGE_HOLD  = '{en: 1'b0, clr: 1'b0};
  localparam stage_ctrl_t STAGE_FLUSH = '{en: 1'b1, clr: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush controls back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [REG_ADDR_W-1:0] i_d_rs1;
  logic [REG_ADDR_W-1:0] i_d_rs2;
  logic                  i_d_use_rs1;
  logic                  i_d_use_rs2;
  logic [REG_ADDR_W-1:0] i_e_rd;
  logic                  i_e_is_load;
  logic                  i_e_muldiv_busy;
  logic                  i_e_redirect;
  logic                  i_imem_ready;
  logic                  i_m_mem_req;
  logic                  i_dmem_ready;
  logic                  o_pc_en;
  logic                  o_pc_sel_redirect;
  logic                  o_fd_en;
  logic                  o_fd_clr;
  logic                  o_de_en;
  logic                  o_de_clr;
  logic                  o_em_en;
  logic                  o_em_clr;
  logic                  o_mw_en;
  logic                  o_mw_clr;
  logic [CNT_WIDTH-1:0]  o_stall_cnt;
  logic [CNT_WIDTH-1:0]  o_flush_cnt;

  // Pipeline side: reports hazards, consumes controls.
  modport master (
    output i_d_rs1, i_d_rs2, i_d_use_rs1, i_d_use_rs2, i_e_rd, i_e_is_load,
           i_e_muldiv_busy, i_e_redirect, i_imem_ready, i_m_mem_req, i_dmem_ready,
    input  o_pc_en, o_pc_sel_redirect, o_fd_en, o_fd_clr, o_de_en, o_de_clr,
           o_em_en, o_em_clr, o_mw_en, o_mw_clr, o_stall_cnt, o_flush_cnt
  );

  // Controller side.
  modport slave (
    input  i_d_rs1, i_d_rs2, i_d_use_rs1, i_d_use_rs2, i_e_rd, i_e_is_load,
           i_e_muldiv_busy, i_e_redirect, i_imem_ready, i_m_mem_req, i_dmem_ready,
    output o_pc_en, o_pc_sel_redirect, o_fd_en, o_fd_clr, o_de_en, o_de_clr,
           o_em_en, o_em_clr, o_mw_en, o_mw_clr, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_chk.sv
// Simulation checks on the hazard controller's inputs and outputs.
module pipeline_hazard_ctrl_chk (
  input logic       i_clock,
  input logic       i_reset,
  input logic       i_muldiv_busy,
  input logic       i_redirect,
  input logic [3:0] i_en,
  input logic [3:0] i_clr
);
  // A redirect cannot resolve while the mul/div unit still occupies E.
  a_no_muldiv_redirect: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_muldiv_busy && i_redirect))
    else $error("illegal: muldiv busy together with redirect");

  // A clear is only meaningful on an enabled stage register.
  a_clr_needs_en: assert property (@(posedge i_clock)
    ((i_clr & ~i_en) == 4'b0000))
    else $error("stage clear asserted without enable");
endmodule

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  // Count up on i_inc, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int CNT_WIDTH  = pipeline_pkg::CNT_WIDTH
) (
  input logic                  i_clock,
  input logic                  i_reset,
  pipeline_hazard_ctrl_if.slave hz
);
  hz_state_e             r_state;
  hz_state_e             w_next_state;
  stage_ctrl_t           w_fd, w_de, w_em, w_mw;
  logic                  w_pc_en, w_pc_sel;
  logic                  w_flush_inc, w_stall_inc;
  logic                  w_dmem_stall, w_load_use;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
  logic [CNT_WIDTH-1:0]  w_stall_cnt, w_flush_cnt;

  assign w_rs1        = hz.i_d_rs1;
  assign w_rs2        = hz.i_d_rs2;
  assign w_rd         = hz.i_e_rd;
  assign w_dmem_stall = hz.i_m_mem_req && !hz.i_dmem_ready;
  // x0 is never a real producer, so a load into it cannot create a hazard.
  assign w_load_use   = hz.i_e_is_load && (w_rd != '0) &&
                        ((hz.i_d_use_rs1 && (w_rs1 == w_rd)) ||
                         (hz.i_d_use_rs2 && (w_rs2 == w_rd)));

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Priority-ordered hazard resolution: picks stage controls and next state.
  always_comb begin
    w_fd         = STAGE_RUN;
    w_de         = STAGE_RUN;
    w_em         = STAGE_RUN;
    w_mw         = STAGE_RUN;
    w_pc_en      = 1'b1;
    w_pc_sel     = 1'b0;
    w_flush_inc  = 1'b0;
    w_next_state = r_state;
    if (i_reset) begin
      w_fd         = STAGE_FLUSH;
      w_de         = STAGE_FLUSH;
      w_em         = STAGE_FLUSH;
      w_mw         = STAGE_FLUSH;
      w_pc_en      = 1'b0;
      w_next_state = RUN;
    end else if (w_dmem_stall) begin
      // E is frozen, so any redirect there is simply seen again next cycle.
      w_pc_en = 1'b0;
      w_fd    = STAGE_HOLD;
      w_de    = STAGE_HOLD;
      w_em    = STAGE_HOLD;
      w_mw    = STAGE_FLUSH;
    end else if (hz.i_e_muldiv_busy) begin
      w_pc_en = 1'b0;
      w_fd    = STAGE_HOLD;
      w_de    = STAGE_HOLD;
      w_em    = STAGE_FLUSH;
    end else if (hz.i_e_redirect) begin
      w_pc_sel    = 1'b1;
      w_fd        = STAGE_FLUSH;
      w_de        = STAGE_FLUSH;
      w_flush_inc = 1'b1;
      // A fetch still in flight will return the wrong-path instruction.
      if (!hz.i_imem_ready) begin
        w_next_state = KILL;
      end else begin
        w_next_state = r_state;
      end
    end else if (w_load_use) begin
      w_pc_en = 1'b0;
      w_fd    = STAGE_HOLD;
      w_de    = STAGE_FLUSH;
    end else if (r_state == KILL) begin
      // Drop the stale response; the PC already holds the redirect target.
      w_pc_en = 1'b0;
      w_fd    = STAGE_FLUSH;
      if (hz.i_imem_ready) begin
        w_next_state = RUN;
      end else begin
        w_next_state = KILL;
      end
    end else if (!hz.i_imem_ready) begin
      w_pc_en = 1'b0;
      w_fd    = STAGE_FLUSH;
    end else begin
      w_next_state = RUN;
    end
  end

  assign w_stall_inc = !i_reset && !w_pc_en;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_stall_inc),
    .o_count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_flush_inc),
    .o_count (w_flush_cnt)
  );

  pipeline_hazard_ctrl_chk u_chk (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_muldiv_busy (hz.i_e_muldiv_busy),
    .i_redirect    (hz.i_e_redirect),
    .i_en          ({w_fd.en, w_de.en, w_em.en, w_mw.en}),
    .i_clr         ({w_fd.clr, w_de.clr, w_em.clr, w_mw.clr})
  );

  assign hz.o_pc_en           = w_pc_en;
  assign hz.o_pc_sel_redirect = w_pc_sel;
  assign hz.o_fd_en           = w_fd.en;
  assign hz.o_fd_clr          = w_fd.clr;
  assign hz.o_de_en           = w_de.en;
  assign hz.o_de_clr          = w_de.clr;
  assign hz.o_em_en           = w_em.en;
  assign hz.o_em_clr          = w_em.clr;
  assign hz.o_mw_en           = w_mw.en;
  assign hz.o_mw_clr          = w_mw.clr;
  assign hz.o_stall_cnt       = w_stall_cnt;
  assign hz.o_flush_cnt       = w_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  // Output vector order: {pc_en, sel, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr}
  localparam logic [9:0] V_RST  = 10'b0_0_11_11_11_11;
  localparam logic [9:0] V_RUN  = 10'b1_0_10_10_10_10;
  localparam logic [9:0] V_LU   = 10'b0_0_00_11_10_10;
  localparam logic [9:0] V_RDR  = 10'b1_1_11_11_10_10;
  localparam logic [9:0] V_WAIT = 10'b0_0_11_10_10_10;
  localparam logic [9:0] V_DMEM = 10'b0_0_00_00_00_11;
  localparam logic [9:0] V_MD   = 10'b0_0_00_00_11_10;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Literal expectations set by the stimulus for the current cycle.
  logic       lit_on;
  logic [9:0] lit_vec;
  logic       lit_cnt_on;
  int         lit_stall, lit_flush;

  // Reference model state.
  logic m_kill = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  // Model scratch (used only by the compare process).
  logic [4:0] en_v, clr_v;
  logic       sel_v, lu_v, dst_v;
  int         stop;
  logic [9:0] exp_v, act_v;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_WIDTH(CW)) hz_if ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_WIDTH(CW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .hz      (hz_if)
  );

  always #5 clk = ~clk;

  // Compare DUT against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    lu_v  = hz_if.i_e_is_load && (hz_if.i_e_rd != 5'd0) &&
            ((hz_if.i_d_use_rs1 && (hz_if.i_d_rs1 == hz_if.i_e_rd)) ||
             (hz_if.i_d_use_rs2 && (hz_if.i_d_rs2 == hz_if.i_e_rd)));
    dst_v = hz_if.i_m_mem_req && !hz_if.i_dmem_ready;
    en_v  = 5'b11111;
    clr_v = 5'b00000;
    sel_v = 1'b0;
    stop  = -1;
    // Index 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
    // A stall at stage s freezes everything upstream of s and bubbles s.
    if (rst) begin
      en_v  = 5'b11110;
      clr_v = 5'b11110;
    end else if (dst_v) stop = 4;
    else if (hz_if.i_e_muldiv_busy) stop = 3;
    else if (hz_if.i_e_redirect) begin
      sel_v = 1'b1;
      clr_v = 5'b00110;
    end else if (lu_v) stop = 2;
    else if (m_kill || !hz_if.i_imem_ready) stop = 1;
    if (stop >= 0) begin
      for (int k = 0; k < 5; k++) begin
        en_v[k]  = (k >= stop);
        clr_v[k] = (k == stop);
      end
    end
    exp_v = {en_v[0], sel_v, en_v[1], clr_v[1], en_v[2], clr_v[2],
             en_v[3], clr_v[3], en_v[4], clr_v[4]};
    act_v = {hz_if.o_pc_en, hz_if.o_pc_sel_redirect, hz_if.o_fd_en, hz_if.o_fd_clr,
             hz_if.o_de_en, hz_if.o_de_clr, hz_if.o_em_en, hz_if.o_em_clr,
             hz_if.o_mw_en, hz_if.o_mw_clr};

    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0t got %b want %b", $time, act_v, exp_v);
    end
    checks++;
    if (hz_if.o_stall_cnt !== CW'(m_stall)) begin
      errors++;
      $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, hz_if.o_stall_cnt, m_stall);
    end
    checks++;
    if (hz_if.o_flush_cnt !== CW'(m_flush)) begin
      errors++;
      $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, hz_if.o_flush_cnt, m_flush);
    end
    if (lit_on) begin
      checks++;
      if (act_v !== lit_vec) begin
        errors++;
        $display("FAIL lit_outputs t=%0t got %b want %b", $time, act_v, lit_vec);
      end
    end
    if (lit_cnt_on) begin
      checks++;
      if ((hz_if.o_stall_cnt !== CW'(lit_stall)) || (hz_if.o_flush_cnt !== CW'(lit_flush))) begin
        errors++;
        $display("FAIL lit_counts t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 $time, hz_if.o_stall_cnt, hz_if.o_flush_cnt, lit_stall, lit_flush);
      end
    end

    // Advance model to what the coming rising edge should produce.
    if (rst) begin
      m_kill  = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!en_v[0] && m_stall < CMAX) m_stall = m_stall + 1;
      if (!dst_v && !hz_if.i_e_muldiv_busy && hz_if.i_e_redirect) begin
        if (m_flush < CMAX) m_flush = m_flush + 1;
        m_kill = m_kill || !hz_if.i_imem_ready;
      end else if (!dst_v && !hz_if.i_e_muldiv_busy && !lu_v && m_kill && hz_if.i_imem_ready) begin
        m_kill = 1'b0;
      end
    end
  end

  task automatic idle();
    rst                   = 1'b0;
    hz_if.i_d_rs1         = 5'd0;
    hz_if.i_d_rs2         = 5'd0;
    hz_if.i_d_use_rs1     = 1'b0;
    hz_if.i_d_use_rs2     = 1'b0;
    hz_if.i_e_rd          = 5'd0;
    hz_if.i_e_is_load     = 1'b0;
    hz_if.i_e_muldiv_busy = 1'b0;
    hz_if.i_e_redirect    = 1'b0;
    hz_if.i_imem_ready    = 1'b1;
    hz_if.i_m_mem_req     = 1'b0;
    hz_if.i_dmem_ready    = 1'b1;
    lit_on                = 1'b0;
    lit_cnt_on            = 1'b0;
  endtask

  task automatic expv(input logic [9:0] v);
    lit_on  = 1'b1;
    lit_vec = v;
  endtask

  task automatic expc(input int s, input int f);
    lit_cnt_on = 1'b1;
    lit_stall  = s;
    lit_flush  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(); rst = 1'b1; tick();
    idle(); rst = 1'b1; expv(V_RST); tick();
    idle(); rst = 1'b1; expv(V_RST); expc(0, 0); tick();
    idle(); expv(V_RUN); tick();
    // lw x5 in E, add x6,x5,x1 in D
    idle(); hz_if.i_e_is_load = 1'b1; hz_if.i_e_rd = 5'd5;
    hz_if.i_d_rs1 = 5'd5; hz_if.i_d_use_rs1 = 1'b1; hz_if.i_d_rs2 = 5'd1; hz_if.i_d_use_rs2 = 1'b1;
    expv(V_LU); tick();
    idle(); expv(V_RUN); expc(1, 0); tick();
    // load into x0 never stalls
    idle(); hz_if.i_e_is_load = 1'b1; hz_if.i_e_rd = 5'd0;
    hz_if.i_d_use_rs1 = 1'b1; hz_if.i_d_use_rs2 = 1'b1; expv(V_RUN); tick();
    // redirect, fetch ready
    idle(); hz_if.i_e_redirect = 1'b1; expv(V_RDR); tick();
    idle(); expv(V_RUN); expc(1, 1); tick();
    // redirect with fetch outstanding, two more busy cycles, then stale response
    idle(); hz_if.i_e_redirect = 1'b1; hz_if.i_imem_ready = 1'b0; expv(V_RDR); tick();
    for (int n = 0; n < 2; n++) begin
      idle(); hz_if.i_imem_ready = 1'b0; expv(V_WAIT); tick();
    end
    idle(); expv(V_WAIT); expc(3, 2); tick();
    idle(); expv(V_RUN); expc(4, 2); tick();
    // dmem stall hides a redirect for 3 cycles
    for (int n = 0; n < 3; n++) begin
      idle(); hz_if.i_m_mem_req = 1'b1; hz_if.i_dmem_ready = 1'b0; hz_if.i_e_redirect = 1'b1;
      expv(V_DMEM);
      if (n == 1) expc(5, 2);
      tick();
    end
    idle(); hz_if.i_m_mem_req = 1'b1; hz_if.i_e_redirect = 1'b1; expv(V_RDR); expc(7, 2); tick();
    idle(); expv(V_RUN); expc(7, 3); tick();
    // muldiv occupancy 4 cycles
    for (int n = 0; n < 4; n++) begin
      idle(); hz_if.i_e_muldiv_busy = 1'b1; expv(V_MD); tick();
    end
    idle(); expv(V_RUN); expc(11, 3); tick();
    for (int n = 0; n < 3; n++) begin
      idle(); hz_if.i_imem_ready = 1'b0; expv(V_WAIT); tick();
    end
    // counter at 14, four more stalls saturate at 15
    for (int n = 0; n < 4; n++) begin
      idle(); hz_if.i_e_muldiv_busy = 1'b1; expv(V_MD);
      if (n == 0) expc(14, 3);
      tick();
    end
    idle(); expv(V_RUN); expc(15, 3); tick();
    // reset while in KILL
    idle(); hz_if.i_e_redirect = 1'b1; hz_if.i_imem_ready = 1'b0; expv(V_RDR); tick();
    idle(); hz_if.i_imem_ready = 1'b0; expv(V_WAIT); tick();
    idle(); rst = 1'b1; expv(V_RST); tick();
    idle(); expv(V_RUN); expc(0, 0); tick();
    // new redirect while in KILL keeps KILL even with a response arriving
    idle(); hz_if.i_e_redirect = 1'b1; hz_if.i_imem_ready = 1'b0; expv(V_RDR); tick();
    idle(); hz_if.i_e_redirect = 1'b1; expv(V_RDR); tick();
    idle(); expv(V_WAIT); expc(0, 2); tick();
    idle(); expv(V_RUN); expc(1, 2); tick();
    // load-use through rs2 only
    idle(); hz_if.i_e_is_load = 1'b1; hz_if.i_e_rd = 5'd7;
    hz_if.i_d_rs2 = 5'd7; hz_if.i_d_use_rs2 = 1'b1; hz_if.i_d_rs1 = 5'd7; expv(V_LU); tick();
    // matching rs1 that is not read
    idle(); hz_if.i_e_is_load = 1'b1; hz_if.i_e_rd = 5'd7;
    hz_if.i_d_rs1 = 5'd7; hz_if.i_d_rs2 = 5'd3; hz_if.i_d_use_rs2 = 1'b1;
    expv(V_RUN); expc(2, 2); tick();
    idle(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
